dual_issue_queue: RTL and testbench
===================================

// Module: dual_issue_queue
// PURPOSE
//  Instruction buffer between fetch and decode of the dual-issue (master/slave) MIPS core.
//  Accepts 0-2 fetched instructions per cycle into a DEPTH-entry circular queue.
//  Each cycle it presents the head pair to the master/slave decode lanes and decides
//  single vs dual issue from pairing rules: the slave lane takes no branch, jump or memory op,
//  and no intra-pair RAW/WAW. Counts single/dual issue events for performance analysis.
// PARAMETERS
//  DEPTH   8   queue entries; power of two, >= 4
//  PC_W    32  program-counter width
//  INST_W  32  instruction width (MIPS32 encoding)
//  CNT_W   32  performance-counter width
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  flush       in   1      branch/jump redirect: discard all entries
//  in_vld      in   2      [0]=slot0 valid, [1]=slot1 valid; [1] only with [0]
//  in_pc0      in   PC_W   PC of older fetched instruction
//  in_inst0    in   INST_W older fetched instruction
//  in_pc1      in   PC_W   PC of younger fetched instruction
//  in_inst1    in   INST_W younger fetched instruction
//  in_rdy      out  1      free entries >= 2
//  stall       in   1      decode hazard stall: no dequeue this cycle
//  iss_vld_m   out  1      master lane holds a valid instruction
//  iss_pc_m    out  PC_W   master PC (queue head)
//  iss_inst_m  out  INST_W master instruction
//  iss_vld_s   out  1      slave lane valid (dual issue this cycle)
//  iss_pc_s    out  PC_W   slave PC (head+1)
//  iss_inst_s  out  INST_W slave instruction
//  cnt_single  out  CNT_W  cycles with exactly one instruction issued
//  cnt_dual    out  CNT_W  cycles with two instructions issued
// BEHAVIOUR
//  - Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, both counters 0; in_rdy=1, iss_vld_m=0, iss_vld_s=0.
//  - Storage: circular array, $clog2(DEPTH)-bit pointers wrapping modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - Push: at edge with in_rdy=1 and flush=0, write popcount(in_vld) entries at wr_ptr, slot0 first.
//    in_vld with in_rdy=0 is ignored; the source holds its data.
//  - Issue outputs are combinational from head (show-ahead): an entry written at edge N appears on iss_* after edge N.
//  - iss_vld_m = count>=1. iss_vld_s = count>=2 AND pair_ok(head, head+1).
//  - pair_ok is 0 if any of:
//     head is branch/jump (beq,bne,blez,bgtz,regimm,j,jal, R-type jr/jalr);
//     second is branch/jump, load (op 100xxx) or store (op 101xxx);
//     head dest != 0 and (dest == second.rs, or dest == second.rt when second reads rt);
//     head dest != 0 and head dest == second dest.
//    dest: R-type -> rd; I-type ALU/load -> rt; jal -> 31; store/branch/j -> none.
//  - Pop: at edge with stall=0 and flush=0, pop iss_vld_m+iss_vld_s entries; rd_ptr advances by the same.
//  - Simultaneous push and pop: count_next = count + pushed - popped; in_rdy is derived from the registered count only.
//  - flush=1 dominates: rd_ptr=wr_ptr=0, count=0 at that edge; same-cycle push and pop are discarded; counters do not increment.
//  - Counters: at a pop edge, cnt_dual++ when 2 popped, cnt_single++ when 1; both wrap at 2^CNT_W. Stalled or empty cycles: no change.
//  - Reset asserted mid-operation clears all state immediately; contents are don't-care after reset.
// STRUCTURE
//  - Shared package mips_isa_pkg: opcode/funct localparams (OP_RTYPE, OP_BEQ, OP_LW, FN_JR, ...), field-slice helper functions.
//  - Sub-module issue_pair_check (combinational): inputs inst_a, inst_b; output pair_ok.
//  - Queue, pointers and counters in the top module. No inferred latches; the storage array is not reset.
// TESTING
//  1. Reset, then push {addu $1,$2,$3 ; addu $4,$5,$6} -> next cycle iss_vld_m=1, iss_vld_s=1; pop -> cnt_dual=1, count=0.
//  2. Push {addu $1,$2,$3 ; addu $4,$1,$6} -> RAW on $1: iss_vld_s=0; issue 1, then 1 -> cnt_single=2.
//  3. Push {addu $1.. ; lw $4,0($5)} -> load: single issue; then lw alone becomes master -> issues.
//  4. Push {beq ; addu} -> single issue; flush same cycle as a push of 2 -> count=0, iss_vld_m=0, counters unchanged.
//  5. DEPTH=8: push 2/cycle with stall=1 -> in_rdy drops when count=7 or 8; release stall -> pointers wrap 7->0, PC order preserved.
//  6. Assert rst low mid-stream while the queue holds 5 entries -> iss_vld_m=0, in_rdy=1, counters=0 before the next clock edge.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS32 opcode/funct constants and field helpers shared by the issue logic.
// Classification functions describe only what the dual-issue pairing rules need.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_JALR   = 6'b001001;
    localparam logic [5:0] FN_ADDU   = 6'b100001;

    function automatic logic [5:0] f_op(input logic [31:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] inst);
        return inst[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] inst);
        return inst[15:11];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] inst);
        return inst[5:0];
    endfunction

    function automatic logic is_branch_jump(input logic [31:0] inst);
        logic [5:0] op;
        op = f_op(inst);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ) ||
               (op == OP_REGIMM) || (op == OP_J) || (op == OP_JAL) ||
               ((op == OP_RTYPE) && ((f_funct(inst) == FN_JR) || (f_funct(inst) == FN_JALR)));
    endfunction

    function automatic logic is_load(input logic [31:0] inst);
        return inst[31:29] == 3'b100;
    endfunction

    function automatic logic is_store(input logic [31:0] inst);
        return inst[31:29] == 3'b101;
    endfunction

    // Zero means "writes no register"; $0 writes are architecturally discarded anyway.
    function automatic logic [4:0] dest_reg(input logic [31:0] inst);
        logic [5:0] op;
        op = f_op(inst);
        if (op == OP_RTYPE)
            return f_rd(inst);
        else if ((inst[31:29] == 3'b001) || is_load(inst))
            return f_rt(inst);
        else if (op == OP_JAL)
            return 5'd31;
        else
            return 5'd0;
    endfunction

    function automatic logic reads_rt(input logic [31:0] inst);
        logic [5:0] op;
        op = f_op(inst);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || is_store(inst);
    endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether the instruction after the head may issue on the slave lane
// in the same cycle as the head (master lane).
module issue_pair_check
    import mips_isa_pkg::*;
(
    input  logic [31:0] inst_a,
    input  logic [31:0] inst_b,
    output logic        pair_ok
);

    logic [4:0] dest_a;
    logic       ctrl_block;
    logic       raw_hazard;
    logic       waw_hazard;

    assign dest_a     = dest_reg(inst_a);
    assign ctrl_block = is_branch_jump(inst_a) || is_branch_jump(inst_b) ||
                        is_load(inst_b) || is_store(inst_b);
    assign raw_hazard = (dest_a != 5'd0) &&
                        ((dest_a == f_rs(inst_b)) || (reads_rt(inst_b) && (dest_a == f_rt(inst_b))));
    assign waw_hazard = (dest_a != 5'd0) && (dest_a == dest_reg(inst_b));
    assign pair_ok    = !(ctrl_block || raw_hazard || waw_hazard);

endmodule

// File: rtl/dual_issue_queue.sv
// Fetch-to-decode instruction queue: accepts up to two instructions per cycle,
// presents the head pair show-ahead and issues one or two per cycle.
module dual_issue_queue
    import mips_isa_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        in_vld,
    input  logic [PC_W-1:0]   in_pc0,
    input  logic [INST_W-1:0] in_inst0,
    input  logic [PC_W-1:0]   in_pc1,
    input  logic [INST_W-1:0] in_inst1,
    output logic              in_rdy,
    input  logic              stall,
    output logic              iss_vld_m,
    output logic [PC_W-1:0]   iss_pc_m,
    output logic [INST_W-1:0] iss_inst_m,
    output logic              iss_vld_s,
    output logic [PC_W-1:0]   iss_pc_s,
    output logic [INST_W-1:0] iss_inst_s,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_dual
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_p1, wr_ptr_p1;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] cnt_single_q, cnt_single_d, cnt_dual_q, cnt_dual_d;
    logic             push_en, pop_en, pair_ok;
    logic [1:0]       push_n, pop_n;

    assign rd_ptr_p1 = rd_ptr_q + 1'b1;
    assign wr_ptr_p1 = wr_ptr_q + 1'b1;

    assign in_rdy  = count_q <= CW'(DEPTH - 2);
    assign push_en = in_rdy && !flush;
    assign pop_en  = !stall && !flush;
    assign push_n  = push_en ? ({1'b0, in_vld[0]} + {1'b0, in_vld[1]}) : 2'd0;
    assign pop_n   = pop_en ? ({1'b0, iss_vld_m} + {1'b0, iss_vld_s}) : 2'd0;

    issue_pair_check u_pair_check (
        .inst_a  (iss_inst_m),
        .inst_b  (iss_inst_s),
        .pair_ok (pair_ok)
    );

    assign iss_vld_m  = count_q != '0;
    assign iss_vld_s  = (count_q >= CW'(2)) && pair_ok;
    assign iss_pc_m   = pc_mem[rd_ptr_q];
    assign iss_inst_m = inst_mem[rd_ptr_q];
    assign iss_pc_s   = pc_mem[rd_ptr_p1];
    assign iss_inst_s = inst_mem[rd_ptr_p1];
    assign cnt_single = cnt_single_q;
    assign cnt_dual   = cnt_dual_q;

    // Storage holds no reset: validity is tracked purely by count_q.
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (in_vld[0]) begin
                pc_mem[wr_ptr_q]   <= in_pc0;
                inst_mem[wr_ptr_q] <= in_inst0;
                if (in_vld[1]) begin
                    pc_mem[wr_ptr_p1]   <= in_pc1;
                    inst_mem[wr_ptr_p1] <= in_inst1;
                end
            end else if (in_vld[1]) begin
                pc_mem[wr_ptr_q]   <= in_pc1;
                inst_mem[wr_ptr_q] <= in_inst1;
            end
        end
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q + AW'(pop_n);
        wr_ptr_d     = wr_ptr_q + AW'(push_n);
        count_d      = count_q + CW'(push_n) - CW'(pop_n);
        cnt_single_d = cnt_single_q + ((pop_n == 2'd1) ? CNT_W'(1) : CNT_W'(0));
        cnt_dual_d   = cnt_dual_q + ((pop_n == 2'd2) ? CNT_W'(1) : CNT_W'(0));
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            cnt_single_q <= '0;
            cnt_dual_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            cnt_single_q <= cnt_single_d;
            cnt_dual_q   <= cnt_dual_d;
        end
    end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: pairing rules, issue counting, flush,
// back-pressure with pointer wrap, and asynchronous reset mid-stream.
module tb_dual_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_vld;
    logic [31:0] in_pc0, in_inst0, in_pc1, in_inst1;
    logic        in_rdy;
    logic        stall;
    logic        iss_vld_m, iss_vld_s;
    logic [31:0] iss_pc_m, iss_inst_m, iss_pc_s, iss_inst_s;
    logic [31:0] cnt_single, cnt_dual;

    int n_checks = 0;
    int n_pass   = 0;

    dual_issue_queue #(.DEPTH(8), .PC_W(32), .INST_W(32), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_vld     (in_vld),
        .in_pc0     (in_pc0),
        .in_inst0   (in_inst0),
        .in_pc1     (in_pc1),
        .in_inst1   (in_inst1),
        .in_rdy     (in_rdy),
        .stall      (stall),
        .iss_vld_m  (iss_vld_m),
        .iss_pc_m   (iss_pc_m),
        .iss_inst_m (iss_inst_m),
        .iss_vld_s  (iss_vld_s),
        .iss_pc_s   (iss_pc_s),
        .iss_inst_s (iss_inst_s),
        .cnt_single (cnt_single),
        .cnt_dual   (cnt_dual)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addu(input int rd, input int rs, input int rt);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'b100001};
    endfunction

    function automatic logic [31:0] lw(input int rt, input int base);
        return {6'b100011, 5'(base), 5'(rt), 16'h0000};
    endfunction

    function automatic logic [31:0] beq(input int rs, input int rt);
        return {6'b000100, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                         input logic [31:0] p1, input logic [31:0] i1);
        in_vld   = v;
        in_pc0   = p0;
        in_inst0 = i0;
        in_pc1   = p1;
        in_inst1 = i1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #3;
        chk("rst_rdy", 32'(in_rdy), 32'd1);
        chk("rst_vld_m", 32'(iss_vld_m), 32'd0);
        chk("rst_vld_s", 32'(iss_vld_s), 32'd0);
        chk("rst_single", cnt_single, 32'd0);
        chk("rst_dual", cnt_dual, 32'd0);
        tick();
        rst = 1'b1;

        // Independent pair -> dual issue
        drive(2'b11, 32'h100, addu(1, 2, 3), 32'h104, addu(4, 5, 6));
        tick();
        in_vld = 2'b00;
        chk("t1_vld_m", 32'(iss_vld_m), 32'd1);
        chk("t1_vld_s", 32'(iss_vld_s), 32'd1);
        chk("t1_pc_m", iss_pc_m, 32'h100);
        chk("t1_pc_s", iss_pc_s, 32'h104);
        chk("t1_inst_s", iss_inst_s, addu(4, 5, 6));
        tick();
        chk("t1_dual", cnt_dual, 32'd1);
        chk("t1_single", cnt_single, 32'd0);
        chk("t1_empty", 32'(iss_vld_m), 32'd0);

        // RAW on $1 -> two single issues
        drive(2'b11, 32'h108, addu(1, 2, 3), 32'h10c, addu(4, 1, 6));
        tick();
        in_vld = 2'b00;
        chk("t2_vld_s", 32'(iss_vld_s), 32'd0);
        tick();
        chk("t2_single1", cnt_single, 32'd1);
        chk("t2_pc_m", iss_pc_m, 32'h10c);
        tick();
        chk("t2_single2", cnt_single, 32'd2);
        chk("t2_empty", 32'(iss_vld_m), 32'd0);

        // Load in the slave slot -> single, then load issues as master
        drive(2'b11, 32'h110, addu(1, 2, 3), 32'h114, lw(4, 5));
        tick();
        in_vld = 2'b00;
        chk("t3_vld_s", 32'(iss_vld_s), 32'd0);
        tick();
        chk("t3_inst_m", iss_inst_m, lw(4, 5));
        chk("t3_pc_m", iss_pc_m, 32'h114);
        tick();
        chk("t3_single", cnt_single, 32'd4);
        chk("t3_empty", 32'(iss_vld_m), 32'd0);

        // Load as head is pairable
        drive(2'b11, 32'h118, lw(4, 5), 32'h11c, addu(6, 7, 8));
        tick();
        in_vld = 2'b00;
        chk("t3b_vld_s", 32'(iss_vld_s), 32'd1);
        tick();
        chk("t3b_dual", cnt_dual, 32'd2);

        // RAW through rt, then WAW: held by stall, cleared by flush
        stall = 1'b1;
        drive(2'b11, 32'h120, addu(7, 2, 3), 32'h124, addu(4, 5, 7));
        tick();
        in_vld = 2'b00;
        chk("t3c_raw_rt", 32'(iss_vld_s), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(2'b11, 32'h128, addu(1, 2, 3), 32'h12c, addu(1, 4, 5));
        tick();
        in_vld = 2'b00;
        chk("t3c_waw", 32'(iss_vld_s), 32'd0);
        chk("t3c_vld_m", 32'(iss_vld_m), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Branch head -> single; flush with concurrent push discards everything
        drive(2'b11, 32'h200, beq(1, 2), 32'h204, addu(4, 5, 6));
        tick();
        chk("t4_vld_m", 32'(iss_vld_m), 32'd1);
        chk("t4_vld_s", 32'(iss_vld_s), 32'd0);
        chk("t4_inst_m", iss_inst_m, beq(1, 2));
        drive(2'b11, 32'h208, addu(9, 2, 3), 32'h20c, addu(10, 2, 3));
        flush = 1'b1;
        stall = 1'b0;
        tick();
        flush = 1'b0;
        in_vld = 2'b00;
        chk("t4_flush_vld", 32'(iss_vld_m), 32'd0);
        chk("t4_flush_rdy", 32'(in_rdy), 32'd1);
        chk("t4_single", cnt_single, 32'd4);
        chk("t4_dual", cnt_dual, 32'd2);

        // Offset pointers by one so the fill wraps 7->0
        stall = 1'b1;
        drive(2'b01, 32'h0f00, addu(30, 20, 21), 32'h0, 32'h0);
        tick();
        in_vld = 2'b00;
        stall = 1'b0;
        chk("t5_off_vld_s", 32'(iss_vld_s), 32'd0);
        tick();
        chk("t5_off_single", cnt_single, 32'd5);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_rdy%0d", k), 32'(in_rdy), 32'd1);
            drive(2'b11, 32'h1000 + 32'(8 * k), addu(2 * k + 1, 20, 21),
                  32'h1004 + 32'(8 * k), addu(2 * k + 2, 20, 21));
            tick();
        end
        chk("t5_full_rdy", 32'(in_rdy), 32'd0);
        drive(2'b11, 32'hdead0000, addu(11, 20, 21), 32'hdead0004, addu(12, 20, 21));
        tick();
        in_vld = 2'b00;
        chk("t5_ignored_rdy", 32'(in_rdy), 32'd0);
        chk("t5_head_pc", iss_pc_m, 32'h1000);
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_vld_s%0d", k), 32'(iss_vld_s), 32'd1);
            chk($sformatf("t5_pc_m%0d", k), iss_pc_m, 32'h1000 + 32'(8 * k));
            chk($sformatf("t5_pc_s%0d", k), iss_pc_s, 32'h1004 + 32'(8 * k));
            tick();
        end
        chk("t5_empty", 32'(iss_vld_m), 32'd0);
        chk("t5_dual", cnt_dual, 32'd6);
        chk("t5_single", cnt_single, 32'd5);
        chk("t5_rdy_end", 32'(in_rdy), 32'd1);

        // Async reset with 5 entries queued
        stall = 1'b1;
        drive(2'b11, 32'h300, addu(1, 20, 21), 32'h304, addu(2, 20, 21));
        tick();
        drive(2'b11, 32'h308, addu(3, 20, 21), 32'h30c, addu(4, 20, 21));
        tick();
        drive(2'b01, 32'h310, addu(5, 20, 21), 32'h0, 32'h0);
        tick();
        in_vld = 2'b00;
        chk("t6_pre_vld_m", 32'(iss_vld_m), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_vld_m", 32'(iss_vld_m), 32'd0);
        chk("t6_vld_s", 32'(iss_vld_s), 32'd0);
        chk("t6_rdy", 32'(in_rdy), 32'd1);
        chk("t6_single", cnt_single, 32'd0);
        chk("t6_dual", cnt_dual, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_post_vld_m", 32'(iss_vld_m), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
